// File: rtl/conv_column_streamer_pkg.sv
// Shared definitions for the column streamer and the convolution controller:
// FSM state encoding, slot-index wrap helper and default geometry.
package conv_column_streamer_pkg;

    localparam int unsigned CONV_KERNEL_SIZE = 3;
    localparam int unsigned CONV_DATA_WIDTH  = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        RUN   = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Advance a line-buffer slot index by one, wrapping modulo the kernel size.
    function automatic int unsigned slot_next(input int unsigned slot, input int unsigned kernel);
        return (slot + 1 >= kernel) ? 0 : slot + 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// KERNEL_SIZE x MAX_WIDTH pixel store, one write port and one combinational
// read port, both addressed by (slot, x). Contents are never reset.
module conv_line_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int MAX_WIDTH   = 64,
    parameter int SLOT_W      = 2,
    parameter int ADDR_W      = 6
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [SLOT_W-1:0]     wr_slot,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [SLOT_W-1:0]     rd_slot,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [KERNEL_SIZE][MAX_WIDTH];

    // Store one accepted pixel into its row slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_slot][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_slot][rd_addr];

endmodule

// File: rtl/conv_column_streamer.sv
// Raster-to-column streamer: buffers KERNEL_SIZE rows and re-emits every
// pixel column of each output band as KERNEL_SIZE beats, top to bottom.
// Optional build macro COLSTREAM_LAST_CHECK_EN: validate s_axis_last on every
// accepted pixel and abort the frame (cfg_err) on a mismatch.
//
// Handshake: a beat moves on either stream when valid && ready at a rising
// clock edge; m_axis_valid/data/last are registered and hold steady while
// valid is high and ready is low.
module conv_column_streamer
    import conv_column_streamer_pkg::*;
#(
    parameter int DATA_WIDTH  = CONV_DATA_WIDTH,
    parameter int KERNEL_SIZE = CONV_KERNEL_SIZE,
    parameter int MAX_WIDTH   = 64,
    parameter int DIM_BITS    = 16
) (
    input  logic                    axi_clk,
    input  logic                    axi_reset_n,
    input  logic                    start,
    input  logic [DIM_BITS-1:0]     image_width,
    input  logic [DIM_BITS-1:0]     image_height,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err,
    input  logic                    s_axis_valid,
    input  logic [DATA_WIDTH-1:0]   s_axis_data,
    output logic                    s_axis_ready,
    input  logic                    s_axis_last,
    output logic                    m_axis_valid,
    output logic [DATA_WIDTH-1:0]   m_axis_data,
    input  logic                    m_axis_ready,
    output logic                    m_axis_last,
    output logic [DATA_WIDTH/8-1:0] m_axis_keep
);

    localparam int SLOT_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int ADDR_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int KEEP_W = DATA_WIDTH / 8;

    state_t                state;
    logic [DIM_BITS-1:0]   width_q;
    logic [DIM_BITS-1:0]   height_q;
    logic [DIM_BITS-1:0]   x;
    logic [DIM_BITS-1:0]   r;
    logic [SLOT_W-1:0]     wr_slot;
    logic [SLOT_W-1:0]     beat_slot;
    logic [SLOT_W-1:0]     k;
    logic                  busy_q;
    logic                  done_q;
    logic                  cfg_err_q;
    logic                  m_valid_q;
    logic                  m_last_q;
    logic [DATA_WIDTH-1:0] m_data_q;

    logic [SLOT_W-1:0]     wr_slot_next;
    logic [SLOT_W-1:0]     rd_slot;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] beat0_data;
    logic                  s_fire;
    logic                  m_fire;
    logic                  last_col;
    logic                  last_pix;
    logic                  last_beat;
    logic                  start_ok;
    logic                  last_bad;

    assign s_axis_ready = (state == PRIME) || (state == RUN);
    assign s_fire       = s_axis_valid && s_axis_ready;
    assign m_fire       = m_valid_q && m_axis_ready;

    assign last_col  = (x == width_q - DIM_BITS'(1));
    assign last_pix  = last_col && (r == height_q - DIM_BITS'(1));
    assign last_beat = (k == SLOT_W'(KERNEL_SIZE - 1));
    assign start_ok  = (image_width >= DIM_BITS'(KERNEL_SIZE)) &&
                       (image_width <= DIM_BITS'(MAX_WIDTH)) &&
                       (image_height >= DIM_BITS'(KERNEL_SIZE));

    // Row r lives in slot r mod K, so the top row of the current window
    // (r-K+1) sits in the slot following the one being written.
    assign wr_slot_next = SLOT_W'(slot_next(32'(wr_slot), KERNEL_SIZE));
    assign rd_slot      = SLOT_W'(slot_next(32'((state == RUN) ? wr_slot : beat_slot), KERNEL_SIZE));

    // With a single-row kernel the first beat is the pixel being written now.
    assign beat0_data = (KERNEL_SIZE == 1) ? s_axis_data : rd_data;

`ifdef COLSTREAM_LAST_CHECK_EN
    assign last_bad = s_fire && (s_axis_last != last_pix);
`else
    logic unused_last;
    assign unused_last = s_axis_last;
    assign last_bad    = 1'b0;
`endif

    conv_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .KERNEL_SIZE(KERNEL_SIZE),
        .MAX_WIDTH  (MAX_WIDTH),
        .SLOT_W     (SLOT_W),
        .ADDR_W     (ADDR_W)
    ) u_line_buffer (
        .clk    (axi_clk),
        .wr_en  (s_fire),
        .wr_slot(wr_slot),
        .wr_addr(x[ADDR_W-1:0]),
        .wr_data(s_axis_data),
        .rd_slot(rd_slot),
        .rd_addr(x[ADDR_W-1:0]),
        .rd_data(rd_data)
    );

    // Frame sequencing, position counters and registered stream/status outputs.
    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            state     <= IDLE;
            width_q   <= '0;
            height_q  <= '0;
            x         <= '0;
            r         <= '0;
            wr_slot   <= '0;
            beat_slot <= '0;
            k         <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // A beat left over from an aborted frame drains here.
                    if (m_fire) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                    end
                    if (start) begin
                        if (start_ok) begin
                            width_q   <= image_width;
                            height_q  <= image_height;
                            cfg_err_q <= 1'b0;
                            busy_q    <= 1'b1;
                            x         <= '0;
                            r         <= '0;
                            wr_slot   <= '0;
                            k         <= '0;
                            state     <= (KERNEL_SIZE == 1) ? RUN : PRIME;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                PRIME: begin
                    if (s_fire) begin
                        if (last_bad) begin
                            cfg_err_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state     <= IDLE;
                        end else if (last_col) begin
                            x       <= '0;
                            r       <= r + DIM_BITS'(1);
                            wr_slot <= wr_slot_next;
                            if (r == DIM_BITS'(KERNEL_SIZE - 2)) begin
                                state <= RUN;
                            end
                        end else begin
                            x <= x + DIM_BITS'(1);
                        end
                    end
                end
                RUN: begin
                    if (s_fire) begin
                        if (last_bad) begin
                            cfg_err_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            m_valid_q <= 1'b1;
                            m_data_q  <= beat0_data;
                            m_last_q  <= (KERNEL_SIZE == 1) && last_pix;
                            k         <= '0;
                            beat_slot <= rd_slot;
                            state     <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (m_fire) begin
                        if (last_beat) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            if (last_pix) begin
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                                state  <= DONE;
                            end else begin
                                state <= RUN;
                                if (last_col) begin
                                    x       <= '0;
                                    r       <= r + DIM_BITS'(1);
                                    wr_slot <= wr_slot_next;
                                end else begin
                                    x <= x + DIM_BITS'(1);
                                end
                            end
                        end else begin
                            k         <= k + SLOT_W'(1);
                            beat_slot <= rd_slot;
                            m_data_q  <= rd_data;
                            m_last_q  <= (k == SLOT_W'(KERNEL_SIZE - 2)) && last_pix;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;
    assign m_axis_valid = m_valid_q;
    assign m_axis_data  = m_data_q;
    assign m_axis_last  = m_last_q;
    assign m_axis_keep  = {KEEP_W{m_valid_q}};

endmodule

// File: tb/tb_conv_column_streamer.sv
// Self-checking bench for conv_column_streamer: randomized frames, a reference
// model of the column order, and a scoreboard monitor on the output stream.
module tb_conv_column_streamer;

    localparam int DW   = 32;
    localparam int K    = 3;
    localparam int MAXW = 64;
    localparam int DB   = 16;
    localparam int KW   = DW / 8;
    localparam int EW   = DW + 1;

    logic          axi_clk      = 1'b0;
    logic          axi_reset_n  = 1'b0;
    logic          start        = 1'b0;
    logic [DB-1:0] image_width  = '0;
    logic [DB-1:0] image_height = '0;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic          s_axis_valid = 1'b0;
    logic [DW-1:0] s_axis_data  = '0;
    logic          s_axis_ready;
    logic          s_axis_last  = 1'b0;
    logic          m_axis_valid;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_ready = 1'b1;
    logic          m_axis_last;
    logic [KW-1:0] m_axis_keep;

    conv_column_streamer #(
        .DATA_WIDTH (DW),
        .KERNEL_SIZE(K),
        .MAX_WIDTH  (MAXW),
        .DIM_BITS   (DB)
    ) dut (
        .axi_clk     (axi_clk),
        .axi_reset_n (axi_reset_n),
        .start       (start),
        .image_width (image_width),
        .image_height(image_height),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .s_axis_valid(s_axis_valid),
        .s_axis_data (s_axis_data),
        .s_axis_ready(s_axis_ready),
        .s_axis_last (s_axis_last),
        .m_axis_valid(m_axis_valid),
        .m_axis_data (m_axis_data),
        .m_axis_ready(m_axis_ready),
        .m_axis_last (m_axis_last),
        .m_axis_keep (m_axis_keep)
    );

    // ---------------- clock / watchdog ----------------
    always #5 axi_clk = ~axi_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int               checks     = 0;
    int               errors     = 0;
    logic [EW-1:0]    exp_q[$];
    logic [DW-1:0]    pix[$];
    int               beats_seen = 0;
    int               done_seen  = 0;
    int               last_seen  = 0;
    int               ready_mode = 0;
    bit               abort_src  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- output monitor ----------------
    bit            stalled   = 0;
    bit            prev_last = 0;
    logic [DW-1:0] held_data = '0;
    logic          held_last = 1'b0;
    logic [EW-1:0] e;

    always @(negedge axi_clk) begin
        if (!axi_reset_n) begin
            stalled   = 0;
            prev_last = 0;
        end else begin
            check("keep", 64'(m_axis_keep), 64'({KW{m_axis_valid}}));
            if (m_axis_valid) check("s_ready_during_emit", 64'(s_axis_ready), 64'(0));
            if (stalled) begin
                check("stall_valid", 64'(m_axis_valid), 64'(1));
                check("stall_data", 64'(m_axis_data), 64'(held_data));
                check("stall_last", 64'(m_axis_last), 64'(held_last));
            end
            if (done) begin
                done_seen++;
                check("done_follows_last", 64'(prev_last), 64'(1));
            end
            prev_last = 0;
            if (m_axis_valid && m_axis_ready) begin
                beats_seen++;
                if (m_axis_last) last_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h, expected no beat", m_axis_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(m_axis_data), 64'(e[DW-1:0]));
                    check("beat_last", 64'(m_axis_last), 64'(e[DW]));
                end
                prev_last = m_axis_last;
            end
            stalled   = m_axis_valid && !m_axis_ready;
            held_data = m_axis_data;
            held_last = m_axis_last;
        end
    end

    // ---------------- downstream ready driver ----------------
    initial begin
        int pat;
        pat = 0;
        forever begin
            @(posedge axi_clk);
            #1;
            case (ready_mode)
                0: m_axis_ready = 1'b1;
                1: begin
                    m_axis_ready = (pat == 0) || (pat == 3);
                    pat = (pat + 1) % 4;
                end
                default: m_axis_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // ---------------- reference model ----------------
    // Each accepted pixel (x, r) with r >= K-1 produces the column
    // pix(x, r-K+1) .. pix(x, r). Only columns whose triggering pixel index is
    // below emit_limit are expected.
    task automatic build_frame(input int w, input int h, input bit seq, input int emit_limit);
        bit lst;
        pix.delete();
        for (int i = 0; i < w * h; i++) pix.push_back(seq ? DW'(i) : DW'($urandom));
        for (int r = K - 1; r < h; r++)
            for (int x = 0; x < w; x++)
                if (r * w + x < emit_limit)
                    for (int k = 0; k < K; k++) begin
                        lst = (emit_limit == w * h) && (r == h - 1) && (x == w - 1) && (k == K - 1);
                        exp_q.push_back({lst, pix[(r - K + 1 + k) * w + x]});
                    end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_frame(input int w, input int h);
        @(posedge axi_clk);
        #1;
        image_width  = DB'(w);
        image_height = DB'(h);
        start        = 1'b1;
        @(posedge axi_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_pixels(input int w, input int h, input int count, input int bad_idx);
        int n;
        for (int i = 0; i < count; i++) begin
            if (abort_src) break;
            if ($urandom_range(0, 3) == 0) begin
                s_axis_valid = 1'b0;
                @(posedge axi_clk);
                #1;
            end
            s_axis_valid = 1'b1;
            s_axis_data  = pix[i];
            s_axis_last  = (i == w * h - 1) || (i == bad_idx);
            n = 0;
            @(negedge axi_clk);
            while (!s_axis_ready && n < 2000 && !abort_src) begin
                @(negedge axi_clk);
                n++;
            end
            if (abort_src) break;
            if (!s_axis_ready) begin
                checks++;
                errors++;
                $display("FAIL src_timeout: pixel %0d not accepted within 2000 cycles", i);
                break;
            end
            @(posedge axi_clk);
            #1;
        end
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int n;
        n = 0;
        while (done_seen == d0 && n < 5000) begin
            @(negedge axi_clk);
            #1;
            n++;
        end
        if (done_seen == d0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done pulse within 5000 cycles");
        end
    endtask

    task automatic run_frame(input int w, input int h, input bit seq, input int mode);
        int d0, l0, b0;
        ready_mode = mode;
        d0 = done_seen;
        l0 = last_seen;
        b0 = beats_seen;
        build_frame(w, h, seq, w * h);
        start_frame(w, h);
        check("busy_after_start", 64'(busy), 64'(1));
        check("cfg_err_after_start", 64'(cfg_err), 64'(0));
        send_pixels(w, h, w * h, -1);
        wait_done(d0);
        check("busy_after_done", 64'(busy), 64'(0));
        check("beat_count", 64'(beats_seen - b0), 64'((h - K + 1) * w * K));
        check("done_count", 64'(done_seen - d0), 64'(1));
        check("last_count", 64'(last_seen - l0), 64'(1));
        check("exp_drained", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_m_valid"}, 64'(m_axis_valid), 64'(0));
        check({tag, "_m_last"}, 64'(m_axis_last), 64'(0));
        check({tag, "_m_data"}, 64'(m_axis_data), 64'(0));
        check({tag, "_m_keep"}, 64'(m_axis_keep), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_cfg_err"}, 64'(cfg_err), 64'(0));
        check({tag, "_s_ready"}, 64'(s_axis_ready), 64'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0, l0, b0, n;

        // reset
        axi_reset_n = 1'b0;
        repeat (3) @(posedge axi_clk);
        @(negedge axi_clk);
        check_idle_outputs("reset");
        @(posedge axi_clk);
        #1;
        axi_reset_n = 1'b1;

        // basic 4x4 frame, pixels 0..15, ready held high
        run_frame(4, 4, 1, 0);

        // same frame under a 1-0-0-1 ready pattern
        run_frame(4, 4, 1, 1);

        // rejected configurations
        start_frame(2, 4);
        check("cfg_err_w2", 64'(cfg_err), 64'(1));
        check("busy_w2", 64'(busy), 64'(0));
        repeat (2) @(negedge axi_clk);
        check("s_ready_w2", 64'(s_axis_ready), 64'(0));
        check("m_valid_w2", 64'(m_axis_valid), 64'(0));
        start_frame(MAXW + 1, 4);
        check("cfg_err_wmax", 64'(cfg_err), 64'(1));
        start_frame(4, K - 1);
        check("cfg_err_hmin", 64'(cfg_err), 64'(1));
        check("busy_hmin", 64'(busy), 64'(0));
        // a good start afterwards clears cfg_err and gives 12 beats
        run_frame(4, 3, 0, 2);

        // reset in the middle of beat 1 of column 2
        ready_mode = 0;
        d0 = done_seen;
        l0 = last_seen;
        b0 = beats_seen;
        abort_src = 0;
        build_frame(4, 4, 1, 16);
        start_frame(4, 4);
        fork
            send_pixels(4, 4, 16, -1);
            begin
                n = 0;
                while (beats_seen < b0 + 8 && n < 2000) begin
                    @(negedge axi_clk);
                    #1;
                    n++;
                end
                if (beats_seen < b0 + 8) begin
                    checks++;
                    errors++;
                    $display("FAIL reset_setup_timeout: got %0d beats expected 8", beats_seen - b0);
                end
                axi_reset_n = 1'b0;
                abort_src   = 1;
            end
        join
        @(negedge axi_clk);
        check_idle_outputs("mid_reset");
        exp_q.delete();
        @(posedge axi_clk);
        #1;
        axi_reset_n = 1'b1;
        abort_src   = 0;
        check("reset_no_done", 64'(done_seen - d0), 64'(0));
        check("reset_no_last", 64'(last_seen - l0), 64'(0));
        run_frame(4, 4, 1, 0);

        // minimum image
        run_frame(3, 3, 1, 0);

        // widest image
        run_frame(MAXW, 3, 0, 2);

        // random frames under random backpressure
        for (int t = 0; t < 4; t++) run_frame($urandom_range(3, 10), $urandom_range(3, 6), 0, 2);

`ifdef COLSTREAM_LAST_CHECK_EN
        // early tlast on pixel 9 aborts the frame
        ready_mode = 0;
        d0 = done_seen;
        l0 = last_seen;
        build_frame(4, 4, 1, 9);
        start_frame(4, 4);
        send_pixels(4, 4, 10, 9);
        repeat (4) @(negedge axi_clk);
        check("abort_cfg_err", 64'(cfg_err), 64'(1));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_s_ready", 64'(s_axis_ready), 64'(0));
        check("abort_no_done", 64'(done_seen - d0), 64'(0));
        check("abort_no_last", 64'(last_seen - l0), 64'(0));
        check("abort_exp_drained", 64'(exp_q.size()), 64'(0));
        run_frame(4, 4, 0, 2);
`endif

        repeat (3) @(negedge axi_clk);
        check("final_exp_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_column_streamer.md
Name: conv_column_streamer

Overview:
- Upstream feeder for the convolution controller. Accepts a raster-order pixel stream (row by row, left to right) over AXI4-Stream.
- Buffers KERNEL_SIZE image rows and re-emits the pixels as vertical columns of KERNEL_SIZE beats, top to bottom, for every x of every output band.
- This is the column-major window order the controller consumes: KERNEL_SIZE² beats to fill its first window, then KERNEL_SIZE beats per horizontal step.

Parameters:
- DATA_WIDTH, 32, pixel and stream data width.
- KERNEL_SIZE, 3, kernel edge length; equals the number of rows buffered.
- MAX_WIDTH, 64, maximum image width; sets the depth of each line buffer.
- DIM_BITS, 16, width of the image dimension inputs.

Ports:
- axi_clk  in  1  clock.
- axi_reset_n  in  1  synchronous, active-low reset.
- start  in  1  begin a frame; sampled only in IDLE.
- image_width  in  DIM_BITS  pixels per row; latched at start.
- image_height  in  DIM_BITS  rows per frame; latched at start.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final output beat completes.
- cfg_err  out  1  sticky; set by a rejected start; cleared by reset or by a later valid start.
- s_axis_valid  in  1  input pixel valid.
- s_axis_data  in  DATA_WIDTH  input pixel.
- s_axis_ready  out  1  input accept.
- s_axis_last  in  1  input end of frame.
- m_axis_valid  out  1  output beat valid.
- m_axis_data  out  DATA_WIDTH  output pixel.
- m_axis_ready  in  1  downstream accept.
- m_axis_last  out  1  last beat of frame.
- m_axis_keep  out  DATA_WIDTH/8  all ones while m_axis_valid, else zero.

Behaviour:
- Reset (axi_reset_n low at a clock edge): all outputs 0, state IDLE, counters 0. Line-buffer contents are not cleared. A reset mid-frame abandons the frame; no done pulse and no tlast are produced.
- Storage: KERNEL_SIZE line buffers × MAX_WIDTH entries. Row r is stored in slot r mod KERNEL_SIZE. Reads are combinational from the register array.
- Handshake: a transfer occurs when valid && ready. m_axis_data, m_axis_last and m_axis_valid are registered and held stable while valid && !ready.
- IDLE: s_axis_ready=0.
  - start with KERNEL_SIZE ≤ width ≤ MAX_WIDTH and KERNEL_SIZE ≤ height: latch dimensions, clear cfg_err, busy=1, go to PRIME.
  - start with dimensions outside those ranges: set cfg_err and stay in IDLE.
- PRIME: s_axis_ready=1. Store rows 0..KERNEL_SIZE-2; no output. After pixel (width-1) of row KERNEL_SIZE-2 is accepted, go to RUN.
- RUN: s_axis_ready=1. Accepting pixel (x, r) writes it into slot r mod K, then go to EMIT at beat k=0.
- EMIT: s_axis_ready=0. Emit K beats; beat k carries the buffered pixel (x, r-K+1+k), so the final beat is the pixel just accepted.
  - The first beat is valid on the cycle after acceptance (latency 1). Each beat is held until m_axis_ready.
  - After beat K-1 is taken, return to RUN, or go to DONE if x = width-1 and r = height-1.
- m_axis_last=1 only on beat K-1 of column width-1 of row height-1.
- DONE: done=1 for one cycle, busy=0, go to IDLE. A start level still high restarts the frame on the next cycle.
- Frame totals: (height-K+1)·width·K output beats; height·width input beats.
- Counters: x wraps from width-1 to 0 and increments r; r never exceeds height-1.
- Input s_axis_last is ignored unless the optional feature below is compiled in.

Optional Feature:
- Macro COLSTREAM_LAST_CHECK_EN.
- Defined: s_axis_last is compared on every accepted pixel against "x = width-1 and r = height-1".
  - A mismatch sets cfg_err and aborts the frame: immediate return to IDLE, no done pulse, no m_axis_last. A beat already presented stays valid until it is taken.
- Undefined: s_axis_last is unused, and frame end is determined purely by the counters.

Decomposition:
- Shared package holds the state enum (IDLE, PRIME, RUN, EMIT, DONE), the slot-index modulo helper, and the KERNEL_SIZE and DATA_WIDTH defaults used by the convolution controller.
- One sub-module, conv_line_buffer: KERNEL_SIZE × MAX_WIDTH register array with one write port and one combinational read port, addressed by (slot, x).

Test Plan:
- Basic frame, K=3, W=4, H=4, pixels 0..15, m_axis_ready=1:
  - Output must be 0,4,8, 1,5,9, 2,6,10, 3,7,11, 4,8,12, 5,9,13, 6,10,14, 7,11,15.
  - 24 beats total; m_axis_last only on the beat carrying 15; done pulses once, one cycle after it.
- Backpressure: same frame with m_axis_ready toggled 1-0-0-1 → identical beat order; data and last stable while stalled; s_axis_ready=0 throughout EMIT.
- Config error: start with width=2, K=3 → cfg_err=1, busy=0, s_axis_ready stays 0. A following start with W=4, H=3 clears cfg_err and emits 12 beats.
- Reset mid-EMIT: assert axi_reset_n=0 during beat 1 of column 2 → next cycle all outputs 0, state IDLE. A new 4×4 frame then reproduces the first scenario's output exactly.
- Minimum image W=3, H=3, pixels 0..8 → output 0,3,6,1,4,7,2,5,8, with last on 8.
- With COLSTREAM_LAST_CHECK_EN defined, s_axis_last asserted on pixel 9 of a 4×4 frame → cfg_err=1, return to IDLE, no done pulse, no m_axis_last.
